// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with occupancy/threshold flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; otherwise rdata is registered on pop.
module sync_fifo_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic push_acc;
    logic pop_acc;

    // Flags come only from the registered count, so a pop never frees a slot
    // for a push in the same cycle (and vice versa).
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (int'(count_q) >= AFULL_LVL);
    assign almost_empty = (int'(count_q) <= AEMPTY_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);

        if (push_acc) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_acc) begin
            rptr_d = rptr_q + PW'(1);
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wptr_q] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = empty ? '0 : mem_q[rptr_q];
`else
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (pop_acc) begin
            rdata_q <= mem_q[rptr_q];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=4) against a queue-based reference model.
// Works for both the registered-read build and the SYNC_FIFO_FWFT_EN build.
module tb_sync_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             full, almost_full, empty, almost_empty, overflow, underflow;
    logic [WIDTH-1:0] rdata;
    logic [2:0]       count;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: queue of stored words, sticky flags, registered read value.
    logic [WIDTH-1:0] model_q[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    logic [WIDTH-1:0] m_rdata = '0;

    logic [16:0] st_act;
    assign st_act = {full, almost_full, empty, almost_empty, count, overflow, underflow, rdata};

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .wdata        (wdata),
        .full         (full),
        .almost_full  (almost_full),
        .pop          (pop),
        .rdata        (rdata),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Expected {full, almost_full, empty, almost_empty, count, overflow, underflow, rdata}.
    function automatic logic [16:0] exp_status();
        int n;
        logic [WIDTH-1:0] rd;
        n = model_q.size();
`ifdef SYNC_FIFO_FWFT_EN
        rd = (n == 0) ? '0 : model_q[0];
`else
        rd = m_rdata;
`endif
        return {n == DEPTH, n >= DEPTH - 1, n == 0, n <= 1, 3'(n), m_ovf, m_unf, rd};
    endfunction

    // One clock of stimulus; model advances from the pre-edge occupancy.
    task automatic do_cycle(input logic p, input logic r, input logic [WIDTH-1:0] d);
        int  n;
        logic pa, ra;
        push  = p;
        pop   = r;
        wdata = d;
        n  = model_q.size();
        pa = p && (n != DEPTH);
        ra = r && (n != 0);
        @(posedge clk);
        if (p && n == DEPTH) m_ovf = 1'b1;
        if (r && n == 0)     m_unf = 1'b1;
        if (ra) m_rdata = model_q.pop_front();
        if (pa) model_q.push_back(d);
        #1;
        $display("t=%0t push=%b pop=%b wdata=%h count=%0d rdata=%h ovf=%b unf=%b",
                 $time, p, r, d, count, rdata, overflow, underflow);
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        model_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic full_reset();
        assert_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL reset_held: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL reset_release: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        full_reset();
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b0, vals[i]);
            total_cnt++;
            if (st_act !== exp_status())
                $display("FAIL fill[%0d]: got %h expected %h", i, st_act, exp_status());
            else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b1, 8'h00);
            total_cnt++;
            if (st_act !== exp_status())
                $display("FAIL drain[%0d]: got %h expected %h", i, st_act, exp_status());
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow_underflow();
        full_reset();
        for (int i = 1; i <= 4; i++) do_cycle(1'b1, 1'b0, 8'(i * 17));
        do_cycle(1'b1, 1'b0, 8'h55);
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL overflow_push: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b1, 8'h00);
            total_cnt++;
            if (st_act !== exp_status())
                $display("FAIL overflow_contents[%0d]: got %h expected %h", i, st_act, exp_status());
            else pass_cnt++;
        end
        do_cycle(1'b0, 1'b1, 8'h00);
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL underflow_pop: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b0, 8'($urandom));
            total_cnt++;
            if (st_act !== exp_status())
                $display("FAIL sticky[%0d]: got %h expected %h", i, st_act, exp_status());
            else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous_boundary();
        full_reset();
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 8'($urandom));
        do_cycle(1'b1, 1'b1, 8'hE7);
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL both_at_full: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
        full_reset();
        do_cycle(1'b1, 1'b1, 8'h7E);
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL both_at_empty: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
        do_cycle(1'b0, 1'b1, 8'h00);
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL both_at_empty_data: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        full_reset();
        do_cycle(1'b1, 1'b0, 8'($urandom));
        do_cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, 1'b1, 8'($urandom));
            total_cnt++;
            if (st_act !== exp_status())
                $display("FAIL b2b[%0d]: got %h expected %h", i, st_act, exp_status());
            else pass_cnt++;
        end
    endtask

    task automatic test_fwft();
        full_reset();
        do_cycle(1'b1, 1'b0, 8'hA5);
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL first_word: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
        do_cycle(1'b0, 1'b1, 8'h00);
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL first_word_pop: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
    endtask

    task automatic test_midstream_reset();
        full_reset();
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 8'($urandom));
        do_cycle(1'b0, 1'b1, 8'h00);
        do_cycle(1'b1, 1'b0, 8'($urandom));
        #2;
        assert_reset();
        #1;
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL async_clear: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
        push = 1'b1;
        pop  = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL reset_hold_edge: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
        reset = 1'b1;
        do_cycle(1'b1, 1'b0, 8'h9C);
        do_cycle(1'b1, 1'b1, 8'h3D);
        total_cnt++;
        if (st_act !== exp_status())
            $display("FAIL post_reset_pair: got %h expected %h", st_act, exp_status());
        else pass_cnt++;
    endtask

    task automatic test_random();
        full_reset();
        for (int i = 0; i < 400; i++) begin
            logic p, r;
            int bias;
            bias = ((i / 40) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(99) < bias);
            r = ($urandom_range(99) < (100 - bias));
            do_cycle(p, r, 8'($urandom));
            total_cnt++;
            if (st_act !== exp_status())
                $display("FAIL random[%0d]: got %h expected %h", i, st_act, exp_status());
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous_boundary();
        test_back_to_back();
        test_fwft();
        test_midstream_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
